// File: rtl/join_pkg.sv
// Shared definitions for the parameterised 4-phase join: FSM states and
// default sizing.
package join_pkg;

  localparam int DEFAULT_SIZE        = 2;
  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } join_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_ff #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [stages-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[stages-2:0], d};
    end
  end

  assign q = r_chain[stages-1];

endmodule

// File: rtl/join_param_sync.sv
// Joins size asynchronous 4-phase request branches into one merged request,
// capturing each branch's bundled data once per transaction.
module join_param_sync
  import join_pkg::*;
#(
  parameter int size        = DEFAULT_SIZE,
  parameter int width       = DEFAULT_WIDTH,
  parameter int sync_stages = DEFAULT_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [size-1:0]         req_in,
  output logic [size-1:0]         ack_in,
  input  logic [size*width-1:0]   data_in,
  output logic                    req_out,
  input  logic                    ack_out,
  output logic [size*width-1:0]   data_out
);

  logic [size-1:0]       w_req_s;
  logic                  w_ack_s;
  join_state_e           r_state;
  logic [size-1:0]       r_arrived;
  logic [size*width-1:0] r_data;
  logic                  r_req_out;
  logic [size-1:0]       r_ack_in;

  for (genvar g = 0; g < size; g++) begin : g_req_sync
    sync_ff #(.stages(sync_stages)) u_req_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_in[g]),
      .q     (w_req_s[g])
    );
  end

  sync_ff #(.stages(sync_stages)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_out),
    .q     (w_ack_s)
  );

  // The all-arrived test uses the registered mask, so SEND starts one edge
  // after the final capture and req_out rises together with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_arrived <= '0;
      r_data    <= '0;
      r_req_out <= 1'b0;
      r_ack_in  <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (&r_arrived) begin
            r_state   <= SEND;
            r_req_out <= 1'b1;
          end else begin
            for (int i = 0; i < size; i++) begin
              if (w_req_s[i] && !r_arrived[i]) begin
                r_data[i*width +: width] <= data_in[i*width +: width];
                r_arrived[i]             <= 1'b1;
              end
            end
          end
        end
        SEND: begin
          if (w_ack_s) begin
            r_state   <= RELEASE;
            r_req_out <= 1'b0;
            r_ack_in  <= '1;
          end
        end
        RELEASE: begin
          if ((w_req_s == '0) && !w_ack_s) begin
            r_state   <= COLLECT;
            r_arrived <= '0;
            r_ack_in  <= '0;
          end
        end
        default: begin
          r_state   <= COLLECT;
          r_arrived <= '0;
          r_req_out <= 1'b0;
          r_ack_in  <= '0;
        end
      endcase
    end
  end

  assign req_out  = r_req_out;
  assign ack_in   = r_ack_in;
  assign data_out = r_data;

endmodule

// File: tb/tb_join_param_sync.sv
// Self-checking bench for join_param_sync: directed handshake scenarios plus
// randomised 4-phase traffic compared every cycle against a behavioural model.
module tb_join_param_sync;

  localparam int SIZE   = 2;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  localparam int GATHER = 0;
  localparam int OFFER  = 1;
  localparam int DRAIN  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [SIZE-1:0]       req_in = '0;
  logic [SIZE-1:0]       ack_in;
  logic [SIZE*WIDTH-1:0] data_in = '0;
  logic                  req_out;
  logic                  ack_out = 1'b0;
  logic [SIZE*WIDTH-1:0] data_out;

  int passCount  = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;

  always #5 clk = ~clk;

  join_param_sync #(
    .size        (SIZE),
    .width       (WIDTH),
    .sync_stages (STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  // Behavioural model: inputs become visible STAGES edges after they are sampled;
  // a transaction gathers every branch once, offers it, then drains.
  logic [SIZE-1:0]  reqHist [STAGES+1];
  logic             ackHist [STAGES+1];
  int               phase;
  bit               gotBranch [SIZE];
  logic [WIDTH-1:0] heldData [SIZE];
  logic             modelReq;
  logic [SIZE-1:0]  modelAck;
  logic [SIZE-1:0]  seenReq;
  logic             seenAck;
  int               gotCount;

  function automatic logic [SIZE*WIDTH-1:0] expData();
    logic [SIZE*WIDTH-1:0] v;
    for (int i = 0; i < SIZE; i++) v[i*WIDTH +: WIDTH] = heldData[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        reqHist[k] = '0;
        ackHist[k] = 1'b0;
      end
      for (int i = 0; i < SIZE; i++) begin
        gotBranch[i] = 1'b0;
        heldData[i]  = '0;
      end
      phase    = GATHER;
      modelReq = 1'b0;
      modelAck = '0;
    end else begin
      for (int k = STAGES; k > 0; k--) begin
        reqHist[k] = reqHist[k-1];
        ackHist[k] = ackHist[k-1];
      end
      reqHist[0] = req_in;
      ackHist[0] = ack_out;
      seenReq = reqHist[STAGES];
      seenAck = ackHist[STAGES];
      gotCount = 0;
      for (int i = 0; i < SIZE; i++) if (gotBranch[i]) gotCount++;
      if (phase == GATHER) begin
        if (gotCount == SIZE) begin
          phase    = OFFER;
          modelReq = 1'b1;
        end else begin
          for (int i = 0; i < SIZE; i++) begin
            if (seenReq[i] && !gotBranch[i]) begin
              gotBranch[i] = 1'b1;
              heldData[i]  = data_in[i*WIDTH +: WIDTH];
            end
          end
        end
      end else if (phase == OFFER) begin
        if (seenAck) begin
          phase    = DRAIN;
          modelReq = 1'b0;
          modelAck = '1;
        end
      end else begin
        if (seenReq == '0 && !seenAck) begin
          phase    = GATHER;
          modelAck = '0;
          for (int i = 0; i < SIZE; i++) gotBranch[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model req_out", 32'(req_out), 32'(modelReq));
      checkOutput("model ack_in", 32'(ack_in), 32'(modelAck));
      checkOutput("model data_out", 32'(data_out), 32'(expData()));
    end
  end

  task automatic edgeSample(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input logic want, input string name);
    int n = 0;
    while (req_out !== want && n < 30) begin
      edgeSample(1);
      n++;
    end
    checkOutput(name, 32'(req_out), 32'(want));
  endtask

  task automatic waitAck(input logic [SIZE-1:0] want, input string name);
    int n = 0;
    while (ack_in !== want && n < 30) begin
      edgeSample(1);
      n++;
    end
    checkOutput(name, 32'(ack_in), 32'(want));
  endtask

  task automatic finishHandshake();
    @(negedge clk);
    ack_out = 1'b1;
    waitAck('1, "finish ack_in high");
    @(negedge clk);
    req_in  = '0;
    ack_out = 1'b0;
    waitAck('0, "finish ack_in low");
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      for (int i = 0; i < SIZE; i++) begin
        if (!req_in[i] && !ack_in[i] && $urandom_range(3) == 0) begin
          req_in[i] = 1'b1;
          data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if (req_in[i] && ack_in[i] && $urandom_range(2) == 0) begin
          req_in[i] = 1'b0;
        end else if (req_in[i] && !ack_in[i] && $urandom_range(15) == 0) begin
          data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      if (!ack_out && req_out && $urandom_range(2) == 0) ack_out = 1'b1;
      else if (!ack_out && !req_out && ack_in == '0 && $urandom_range(19) == 0) ack_out = 1'b1;
      else if (ack_out && ack_in == '1 && $urandom_range(2) == 0) ack_out = 1'b0;
    end
  endtask

  initial begin
    logic [SIZE*WIDTH-1:0] keptData;
    repeat (3) @(negedge clk);
    checkOutput("reset req_out", 32'(req_out), 32'h0);
    checkOutput("reset ack_in", 32'(ack_in), 32'h0);
    checkOutput("reset data_out", 32'(data_out), 32'h0);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    // Basic join: latency from the second request, then completion.
    @(negedge clk);
    data_in = 16'hB2A1;
    req_in  = 2'b01;
    repeat (10) @(negedge clk);
    req_in = 2'b11;
    edgeSample(3);
    checkOutput("join req_out before latency", 32'(req_out), 32'h0);
    edgeSample(1);
    checkOutput("join req_out at latency", 32'(req_out), 32'h1);
    checkOutput("join data_out", 32'(data_out), 32'hB2A1);
    @(negedge clk);
    ack_out = 1'b1;
    edgeSample(2);
    checkOutput("completion req_out held", 32'(req_out), 32'h1);
    edgeSample(1);
    checkOutput("completion req_out low", 32'(req_out), 32'h0);
    checkOutput("completion ack_in high", 32'(ack_in), 32'h3);
    @(negedge clk);
    req_in  = 2'b00;
    ack_out = 1'b0;
    edgeSample(2);
    checkOutput("drain ack_in still high", 32'(ack_in), 32'h3);
    edgeSample(1);
    checkOutput("drain ack_in low", 32'(ack_in), 32'h0);
    checkOutput("drain state collect", 32'(dut.r_state), 32'(join_pkg::COLLECT));

    // Sticky capture: branch 0 data changes after it has arrived.
    @(negedge clk);
    data_in = 16'h3311;
    req_in  = 2'b01;
    repeat (5) @(negedge clk);
    data_in = 16'h4422;
    repeat (3) @(negedge clk);
    req_in = 2'b11;
    edgeSample(4);
    checkOutput("sticky req_out", 32'(req_out), 32'h1);
    checkOutput("sticky data_out", 32'(data_out), 32'h4411);
    finishHandshake();

    // Early acknowledge: req_out lasts exactly one cycle.
    @(negedge clk);
    ack_out = 1'b1;
    repeat (4) @(negedge clk);
    data_in = 16'h5A6B;
    req_in  = 2'b11;
    waitReq(1'b1, "early ack req_out rise");
    edgeSample(1);
    checkOutput("early ack req_out one cycle", 32'(req_out), 32'h0);
    checkOutput("early ack ack_in high", 32'(ack_in), 32'h3);
    checkOutput("early ack data_out", 32'(data_out), 32'h5A6B);
    @(negedge clk);
    req_in  = '0;
    ack_out = 1'b0;
    waitAck('0, "early ack drain");

    // Late release: a branch keeps requesting while in RELEASE.
    @(negedge clk);
    data_in = 16'hC3D4;
    req_in  = 2'b11;
    waitReq(1'b1, "late release req_out");
    @(negedge clk);
    ack_out = 1'b1;
    waitAck('1, "late release ack_in high");
    @(negedge clk);
    req_in  = 2'b10;
    ack_out = 1'b0;
    data_in = 16'hEEFF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("late release ack_in held", 32'(ack_in), 32'h3);
    end
    checkOutput("late release no capture", 32'(data_out), 32'hC3D4);
    req_in = 2'b00;
    edgeSample(2);
    checkOutput("late release ack_in before exit", 32'(ack_in), 32'h3);
    edgeSample(1);
    checkOutput("late release ack_in after exit", 32'(ack_in), 32'h0);
    edgeSample(3);
    checkOutput("late release data kept", 32'(data_out), 32'hC3D4);

    // Asynchronous reset in the middle of SEND.
    @(negedge clk);
    data_in = 16'h9876;
    req_in  = 2'b11;
    waitReq(1'b1, "reset setup req_out");
    @(negedge clk);
    keptData = data_out;
    checkOutput("reset setup data_out", 32'(keptData), 32'h9876);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset req_out", 32'(req_out), 32'h0);
    checkOutput("async reset ack_in", 32'(ack_in), 32'h0);
    checkOutput("async reset data_out", 32'(data_out), 32'h0);
    req_in  = '0;
    ack_out = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3000);

    @(negedge clk);
    checkEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/join_param_sync.md
JOIN_PARAM_SYNC -- requirements
Module: join_param_sync

Interface
REQ-001 Parameter size, default 2: number of input branches, at least 2.
REQ-002 Parameter width, default 8: data bits per branch, at least 1.
REQ-003 Parameter sync_stages, default 2: synchronizer depth on every asynchronous input, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_in  input  size  per-branch 4-phase request, asynchronous to clk.
REQ-007 ack_in  output  size  per-branch 4-phase acknowledge, registered.
REQ-008 data_in  input  size*width  bundled data; branch i occupies bits [i*width +: width], stable while req_in[i]=1.
REQ-009 req_out  output  1  merged 4-phase request, registered.
REQ-010 ack_out  input  1  downstream acknowledge, asynchronous to clk.
REQ-011 data_out  output  size*width  captured branch data, same bit layout as data_in, registered.

Function
REQ-012 req_in and ack_out SHALL pass through sync_stages flops before any use; req_s and ack_s denote the synchronized values.
REQ-013 FSM states SHALL be COLLECT, SEND and RELEASE; the reset state is COLLECT.
REQ-014 In COLLECT, req_out=0 and ack_in=0.
REQ-015 In COLLECT, when req_s[i]=1 and arrived[i]=0, the block SHALL capture data_in slice i into data_out slice i and set arrived[i] in the same edge.
REQ-016 arrived[i] SHALL be sticky and SHALL NOT recapture: a later change of req_in[i] or data_in slice i in COLLECT has no effect.
REQ-017 COLLECT to SEND when arrived is all ones, evaluated on registered arrived; transition occurs one cycle after the last capture.
REQ-018 In SEND, req_out=1 and data_out is held constant.
REQ-019 SEND to RELEASE when ack_s=1.
REQ-020 If ack_s is already 1 on entry to SEND, the transition to RELEASE occurs on the next edge; req_out is still high for at least one cycle.
REQ-021 In RELEASE, req_out=0 and ack_in is all ones.
REQ-022 RELEASE to COLLECT when req_s is all zeros and ack_s=0 in the same cycle.
REQ-023 On the RELEASE to COLLECT transition, arrived clears to zero and ack_in returns to 0.
REQ-024 data_out SHALL hold its value until overwritten by the next capture.
REQ-025 A branch raising req_in during SEND or RELEASE SHALL be ignored until COLLECT is re-entered.
REQ-026 Latency SHALL be exactly sync_stages+2 clk edges from the last req_in rising to req_out=1, counting from the first edge that samples the new value.
REQ-027 Latency SHALL be exactly sync_stages+1 edges from ack_out rising to req_out=0 and ack_in all ones.
REQ-028 All outputs SHALL be glitch-free registered values; no combinational path from any input to any output.

Reset
REQ-029 rst_n=0 SHALL immediately force req_out=0, ack_in=0, data_out=0, arrived=0, FSM=COLLECT and all synchronizer flops to 0, independent of clk.
REQ-030 Reset asserted mid-handshake, in any state, SHALL abandon the transaction; after release the block restarts cleanly from COLLECT.
REQ-031 Reset deassertion SHALL take effect on the first clk edge after rst_n=1.

Structure
REQ-032 Package join_pkg SHALL hold the FSM state enum (COLLECT, SEND, RELEASE) and the default values of size, width and sync_stages.
REQ-033 Sub-module sync_ff (parameter stages, 1-bit, async active-low reset to 0) SHALL be instantiated per synchronized input.
REQ-034 The remaining logic SHALL be a single always_ff block plus output assignments.

Verification
REQ-035 Reset: assert rst_n=0 mid-SEND -> req_out=0, ack_in=2'b00, data_out=0 without waiting for a clk edge.
REQ-036 Basic join (size=2): data_in={8'hB2,8'hA1}, raise req_in=2'b01, then 2'b11 ten cycles later, ack_out=0.
 -> req_out=1 exactly 4 edges after req_in[1] rises; data_out=16'hB2A1.
REQ-037 Completion: continue REQ-036, raise ack_out.
 -> 3 edges later req_out=0 and ack_in=2'b11.
 -> drop req_in to 2'b00 and ack_out to 0; ack_in=2'b00 and state COLLECT.
REQ-038 Sticky capture: req_in[0] rises with data 8'h11, then data_in slice 0 changes to 8'h22 before req_in[1] rises -> data_out slice 0 = 8'h11.
REQ-039 Early ack: ack_out=1 held from start -> req_out is high exactly one cycle, then RELEASE.
REQ-040 Late release: in RELEASE, hold req_in=2'b10 for 20 cycles -> ack_in stays 2'b11 and no new capture occurs; release proceeds only once req_in=2'b00.
